// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage divider: op encodings, FSM states, default width.
package alu_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIXUP,
        S_DONE
    } div_state_t;

    // Bit 0 clear selects the signed variants, bit 1 set selects the remainder.
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/alu_div_step.sv
// One restoring radix-2 iteration: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and shift the outcome into the quotient.
module alu_div_step
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-2:0] i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_div,
    output logic [XLEN-1:0] o_rem,
    output logic [XLEN-1:0] o_quo
);

    logic [XLEN-1:0] w_shift;
    logic [XLEN:0]   w_trial;

    // The partial remainder's top bit is always zero before the shift, so it is not an input.
    assign w_shift = {i_rem, i_quo[XLEN-1]};
    assign w_trial = {1'b0, w_shift} - {1'b0, i_div};
    assign o_rem   = w_trial[XLEN] ? w_shift : w_trial[XLEN-1:0];
    assign o_quo   = {i_quo[XLEN-2:0], ~w_trial[XLEN]};

endmodule

// File: rtl/alu_div.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit with valid/ready request and response ports.
// ALU_DIV_FAST_EN: divide-by-zero and signed overflow skip the iteration and go straight to DONE.
module alu_div
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] op_result,
    output logic            busy
);

    localparam int unsigned CW = $clog2(XLEN);

    div_state_t      r_state;
    div_state_t      w_state_nxt;
    logic            r_is_rem;
    logic            r_sign_a;
    logic            r_sign_b;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_div;
    logic [XLEN-1:0] r_result;
    logic [CW-1:0]   r_cnt;
    logic            r_req_ready;
    logic            r_rsp_valid;
    logic            r_busy;

    logic            w_accept;
    logic            w_sgn;
    logic            w_sign_a;
    logic            w_sign_b;
    logic            w_fast;
    logic [XLEN-1:0] w_abs_a;
    logic [XLEN-1:0] w_abs_b;
    logic [XLEN-1:0] w_rem_step;
    logic [XLEN-1:0] w_quo_step;
    logic [XLEN-1:0] w_quo_fix;
    logic [XLEN-1:0] w_rem_fix;

    assign w_accept = req_valid & r_req_ready & ~flush;
    assign w_sgn    = op_is_signed(req_op);
    assign w_sign_a = w_sgn & op_a[XLEN-1];
    assign w_sign_b = w_sgn & op_b[XLEN-1];
    assign w_abs_a  = w_sign_a ? XLEN'(-op_a) : op_a;
    assign w_abs_b  = w_sign_b ? XLEN'(-op_b) : op_b;

`ifdef ALU_DIV_FAST_EN
    logic            w_div_zero;
    logic            w_ovf;
    logic [XLEN-1:0] w_fast_result;

    assign w_div_zero    = (op_b == '0);
    assign w_ovf         = w_sgn & (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (op_b == '1);
    assign w_fast        = w_div_zero | w_ovf;
    assign w_fast_result = op_is_rem(req_op) ? (w_div_zero ? op_a : '0)
                                             : (w_div_zero ? '1 : op_a);
`else
    assign w_fast = 1'b0;
`endif

    alu_div_step #(
        .XLEN (XLEN)
    ) u_step (
        .i_rem (r_rem[XLEN-2:0]),
        .i_quo (r_quo),
        .i_div (r_div),
        .o_rem (w_rem_step),
        .o_quo (w_quo_step)
    );

    // Zero divisor keeps the all-ones quotient regardless of operand signs.
    assign w_quo_fix = ((r_sign_a ^ r_sign_b) && (r_div != '0)) ? XLEN'(-r_quo) : r_quo;
    assign w_rem_fix = r_sign_a ? XLEN'(-r_rem) : r_rem;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_ready <= (w_state_nxt == S_IDLE);
            r_rsp_valid <= (w_state_nxt == S_DONE);
            r_busy      <= (w_state_nxt != S_IDLE);
        end
    end

    // Flush overrides every other transition; reset is handled in the register above.
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_accept) w_state_nxt = w_fast ? S_DONE : S_CALC;
                S_CALC:  if (r_cnt == '0) w_state_nxt = S_FIXUP;
                S_FIXUP: w_state_nxt = S_DONE;
                S_DONE:  if (r_rsp_valid & rsp_ready) w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_is_rem <= 1'b0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_is_rem <= op_is_rem(req_op);
                        r_sign_a <= w_sign_a;
                        r_sign_b <= w_sign_b;
                        r_rem    <= '0;
                        r_quo    <= w_abs_a;
                        r_div    <= w_abs_b;
                        r_cnt    <= CW'(XLEN - 1);
`ifdef ALU_DIV_FAST_EN
                        if (w_fast) r_result <= w_fast_result;
`endif
                    end
                end
                S_CALC: begin
                    r_rem <= w_rem_step;
                    r_quo <= w_quo_step;
                    r_cnt <= r_cnt - CW'(1);
                end
                S_FIXUP: r_result <= r_is_rem ? w_rem_fix : w_quo_fix;
                default: ;
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign busy      = r_busy;
    assign op_result = r_result;

endmodule

// File: tb/tb_alu_div.sv
// Self-checking bench for alu_div: vector table with a result scoreboard plus abort/backpressure sequences.
module tb_alu_div;
    import alu_pkg::*;

    localparam int unsigned XLEN     = 32;
    localparam int          LAT_FULL = XLEN + 2;
`ifdef ALU_DIV_FAST_EN
    localparam int          LAT_FAST = 1;
`else
    localparam int          LAT_FAST = XLEN + 2;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_op;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] op_result;
    logic            busy;

    alu_div #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .op_a      (op_a),
        .op_b      (op_b),
        .flush     (flush),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .op_result (op_result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          fast;
        string       name;
    } vec_t;

    vec_t        vq[$];
    logic [31:0] sb_q[$];
    int          n_pass  = 0;
    int          n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic add(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit fast, input string name);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.exp = exp; v.fast = fast; v.name = name;
        vq.push_back(v);
    endtask

    // Status triple {rsp_valid, busy, req_ready}: 3'b001 means idle.
    function automatic logic [31:0] status();
        return {29'b0, rsp_valid, busy, req_ready};
    endfunction

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        req_op = op; op_a = a; op_b = b; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_op    = 2'($urandom);
        op_a      = $urandom;
        op_b      = $urandom;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic do_op(input vec_t v);
        int          lat;
        logic [31:0] e;
        sb_q.push_back(v.exp);
        issue(v.op, v.a, v.b);
        wait_rsp(lat);
        check({v.name, " latency"}, 32'(lat), 32'(v.fast ? LAT_FAST : LAT_FULL));
        e = sb_q.pop_front();
        check({v.name, " result"}, op_result, e);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({v.name, " idle"}, status(), 32'b001);
        @(posedge clk); #1;
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        bit seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (rsp_valid || busy) seen = 1'b1;
        end
        check(name, 32'(seen), 32'd0);
    endtask

    initial begin
        int          lat;
        logic [31:0] e;
        vec_t        v;

        rst_n = 1'b0; req_valid = 1'b0; req_op = 2'b00; op_a = '0; op_b = '0;
        flush = 1'b0; rsp_ready = 1'b0;

        add(DIV_OP_DIV,  32'd20,       32'hFFFFFFFD, 32'hFFFFFFFA, 1'b0, "div_20_m3");
        add(DIV_OP_REM,  32'd20,       32'hFFFFFFFD, 32'h00000002, 1'b0, "rem_20_m3");
        add(DIV_OP_DIVU, 32'hFFFFFFFF, 32'd2,        32'h7FFFFFFF, 1'b0, "divu_max_2");
        add(DIV_OP_REMU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 1'b0, "remu_max_2");
        add(DIV_OP_DIV,  32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 1'b1, "div_m7_0");
        add(DIV_OP_REM,  32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1'b1, "rem_m7_0");
        add(DIV_OP_DIVU, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1, "divu_5_0");
        add(DIV_OP_REMU, 32'd5,        32'd0,        32'h00000005, 1'b1, "remu_5_0");
        add(DIV_OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, "div_ovf");
        add(DIV_OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1, "rem_ovf");
        add(DIV_OP_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, "divu_nonovf");
        add(DIV_OP_REMU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, "remu_nonovf");
        add(DIV_OP_DIV,  32'hFFFFFFEC, 32'd3,        32'hFFFFFFFA, 1'b0, "div_m20_3");
        add(DIV_OP_REM,  32'hFFFFFFEC, 32'd3,        32'hFFFFFFFE, 1'b0, "rem_m20_3");
        add(DIV_OP_DIV,  32'hFFFFFFEB, 32'hFFFFFFFC, 32'h00000005, 1'b0, "div_m21_m4");
        add(DIV_OP_REM,  32'hFFFFFFEB, 32'hFFFFFFFC, 32'hFFFFFFFF, 1'b0, "rem_m21_m4");
        add(DIV_OP_DIV,  32'h80000000, 32'd2,        32'hC0000000, 1'b0, "div_min_2");
        add(DIV_OP_DIVU, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, "divu_big");
        add(DIV_OP_REMU, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, "remu_big");

        repeat (2) @(posedge clk);
        #1;
        check("reset status", status(), 32'b001);
        check("reset result", op_result, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vq[i]) do_op(vq[i]);

        // Backpressure: result and handshake held while rsp_ready stays low.
        sb_q.push_back(32'd14);
        issue(DIV_OP_DIVU, 32'd100, 32'd7);
        wait_rsp(lat);
        check("bp latency", 32'(lat), 32'(LAT_FULL));
        e = sb_q.pop_front();
        check("bp result", op_result, e);
        req_op = DIV_OP_REMU; op_a = 32'd9; op_b = 32'd4; req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp hold status", {29'b0, rsp_valid, req_ready, busy}, 32'b101);
            check("bp hold result", op_result, e);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("bp release idle", status(), 32'b001);
        @(posedge clk); #1;

        // Reset during CALC discards the operation.
        issue(DIV_OP_DIV, 32'd20, 32'hFFFFFFFD);
        repeat (4) @(posedge clk);
        #1;
        check("pre-reset busy", status(), 32'b010);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("mid reset status", status(), 32'b001);
        check("mid reset result", op_result, 32'h0);
        expect_quiet("mid reset quiet", 40);

        // Flush during CALC of a new op.
        issue(DIV_OP_DIVU, 32'd1000, 32'd3);
        repeat (6) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("calc flush status", status(), 32'b001);
        expect_quiet("calc flush quiet", 40);
        v.op = DIV_OP_DIVU; v.a = 32'd100; v.b = 32'd7; v.exp = 32'd14; v.fast = 1'b0;
        v.name = "divu_after_abort";
        do_op(v);

        // Flush on the accept edge drops the request.
        req_op = DIV_OP_DIVU; op_a = 32'd50; op_b = 32'd5; req_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b0;
        check("accept flush status", status(), 32'b001);
        expect_quiet("accept flush quiet", 40);

        // Flush coinciding with the DONE handshake returns to IDLE once.
        issue(DIV_OP_REMU, 32'd100, 32'd7);
        wait_rsp(lat);
        check("done flush result", op_result, 32'd2);
        flush = 1'b1; rsp_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; rsp_ready = 1'b0;
        check("done flush status", status(), 32'b001);
        expect_quiet("done flush quiet", 5);

        v.op = DIV_OP_REMU; v.a = 32'd100; v.b = 32'd7; v.exp = 32'd2; v.fast = 1'b0;
        v.name = "remu_final";
        do_op(v);

        check("scoreboard drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
